tmr_vote_stage: RTL and testbench

//  Registered majority-vote stage that sits directly upstream of a voted-input

---
 rtl/tmr_vote_stage_if.sv | 28 ++
 rtl/tmr_vote_stage.sv | 104 ++++++++++
 tb/tb_tmr_vote_stage.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/tmr_vote_stage_if.sv
// Bus bundle for the TMR vote stage: three replicas in, voted word and health flags out.
interface tmr_vote_stage_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
);
   logic             in_valid;
   logic [WIDTH-1:0] d_a;
   logic [WIDTH-1:0] d_b;
   logic [WIDTH-1:0] d_c;
   logic             clr;
   logic [WIDTH-1:0] q;
   logic             q_valid;
   logic             mismatch;
   logic [2:0]       bad_replica;
   logic [CNT_W-1:0] err_cnt;
   logic             err_sticky;
   logic [2:0]       replica_fail;

   modport master (
      output in_valid, d_a, d_b, d_c, clr,
      input  q, q_valid, mismatch, bad_replica, err_cnt, err_sticky, replica_fail
   );

   modport slave (
      input  in_valid, d_a, d_b, d_c, clr,
      output q, q_valid, mismatch, bad_replica, err_cnt, err_sticky, replica_fail
   );
endinterface

// File: rtl/tmr_vote_stage.sv
// Registered bitwise majority vote over three replicas, with disagreement
// pulse, saturating upset counter and per-replica persistent-fault flags.
module tmr_vote_stage #(
   parameter int WIDTH       = 8,
   parameter int CNT_W       = 8,
   parameter int PERSIST_THR = 4
) (
   input logic             c,
   input logic             rst_b,
   tmr_vote_stage_if.slave bus
);
   localparam int              PW      = $clog2(PERSIST_THR + 1);
   localparam logic [PW-1:0]   THR_V   = PW'(PERSIST_THR);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [WIDTH-1:0] vote_next;
   logic [WIDTH-1:0] rep [3];
   logic [2:0]       bad_next;
   logic [2:0]       fail_vec;

   logic [WIDTH-1:0] q_reg;
   logic             q_valid_reg;
   logic             mismatch_reg;
   logic [2:0]       bad_replica_reg;
   logic [CNT_W-1:0] err_cnt_reg;
   logic             err_sticky_reg;

   assign vote_next = (bus.d_a & bus.d_b) | (bus.d_b & bus.d_c) | (bus.d_a & bus.d_c);
   assign rep[0]    = bus.d_a;
   assign rep[1]    = bus.d_b;
   assign rep[2]    = bus.d_c;

   // Data path: q holds across invalid cycles, the status pulses do not.
   always_ff @(posedge c or negedge rst_b) begin
      if (!rst_b) begin
         q_reg           <= '0;
         q_valid_reg     <= 1'b0;
         mismatch_reg    <= 1'b0;
         bad_replica_reg <= 3'b000;
      end else if (bus.in_valid) begin
         q_reg           <= vote_next;
         q_valid_reg     <= 1'b1;
         mismatch_reg    <= |bad_next;
         bad_replica_reg <= bad_next;
      end else begin
         q_valid_reg     <= 1'b0;
         mismatch_reg    <= 1'b0;
         bad_replica_reg <= 3'b000;
      end
   end

   // Shared health state; clr takes priority over a coincident mismatch.
   always_ff @(posedge c or negedge rst_b) begin
      if (!rst_b) begin
         err_cnt_reg    <= '0;
         err_sticky_reg <= 1'b0;
      end else if (bus.clr) begin
         err_cnt_reg    <= '0;
         err_sticky_reg <= 1'b0;
      end else if (bus.in_valid && (|bad_next)) begin
         err_sticky_reg <= 1'b1;
         if (err_cnt_reg != CNT_MAX)
            err_cnt_reg <= err_cnt_reg + 1'b1;
      end
   end

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_replica
         logic [PW-1:0] pcnt_reg;
         logic          fail_reg;

         assign bad_next[gi] = |(rep[gi] ^ vote_next);
         assign fail_vec[gi] = fail_reg;

         // Run length of consecutive bad valid samples; a good sample restarts it.
         always_ff @(posedge c or negedge rst_b) begin
            if (!rst_b) begin
               pcnt_reg <= '0;
               fail_reg <= 1'b0;
            end else if (bus.clr) begin
               pcnt_reg <= '0;
               fail_reg <= 1'b0;
            end else if (bus.in_valid) begin
               if (bad_next[gi]) begin
                  if (pcnt_reg != THR_V)
                     pcnt_reg <= pcnt_reg + 1'b1;
                  if (pcnt_reg >= THR_V - 1'b1)
                     fail_reg <= 1'b1;
               end else begin
                  pcnt_reg <= '0;
               end
            end
         end
      end
   endgenerate

   assign bus.q            = q_reg;
   assign bus.q_valid      = q_valid_reg;
   assign bus.mismatch     = mismatch_reg;
   assign bus.bad_replica  = bad_replica_reg;
   assign bus.err_cnt      = err_cnt_reg;
   assign bus.err_sticky   = err_sticky_reg;
   assign bus.replica_fail = fail_vec;
endmodule

// File: tb/tb_tmr_vote_stage.sv
// Bench for tmr_vote_stage: two instances (CNT_W=8 and CNT_W=2) share one stimulus
// stream and are checked every cycle against a behavioural model plus literal pins.
module tb_tmr_vote_stage;
   logic c = 1'b0;
   logic rst_b = 1'b0;
   int   n_tests = 0;
   int   n_fail = 0;

   tmr_vote_stage_if #(.WIDTH(8), .CNT_W(8)) bus_a ();
   tmr_vote_stage_if #(.WIDTH(8), .CNT_W(2)) bus_b ();

   tmr_vote_stage #(.WIDTH(8), .CNT_W(8), .PERSIST_THR(4)) dut_a (
      .c(c), .rst_b(rst_b), .bus(bus_a));
   tmr_vote_stage #(.WIDTH(8), .CNT_W(2), .PERSIST_THR(4)) dut_b (
      .c(c), .rst_b(rst_b), .bus(bus_b));

   always #5 c = ~c;

   // Behavioural model: majority by counting ones per bit, counters as plain ints.
   function automatic logic [7:0] maj(input logic [7:0] a, input logic [7:0] b, input logic [7:0] d);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) begin
         int ones;
         ones = int'(a[i]) + int'(b[i]) + int'(d[i]);
         r[i] = (ones >= 2);
      end
      return r;
   endfunction

   logic [7:0] in_vote;
   logic [2:0] in_bad;
   always_comb begin
      in_vote = maj(bus_a.d_a, bus_a.d_b, bus_a.d_c);
      in_bad  = {bus_a.d_c != in_vote, bus_a.d_b != in_vote, bus_a.d_a != in_vote};
   end

   logic [7:0] m_q = 8'h00;
   logic       m_qv = 1'b0;
   logic       m_mis = 1'b0;
   logic [2:0] m_bad = 3'b000;
   logic       m_sticky = 1'b0;
   logic [2:0] m_fail = 3'b000;
   int         m_cnt_a = 0;
   int         m_cnt_b = 0;
   int         m_pc [3] = '{0, 0, 0};

   always @(posedge c or negedge rst_b) begin
      if (!rst_b) begin
         m_q <= 8'h00; m_qv <= 1'b0; m_mis <= 1'b0; m_bad <= 3'b000;
         m_sticky <= 1'b0; m_fail <= 3'b000; m_cnt_a <= 0; m_cnt_b <= 0;
         for (int i = 0; i < 3; i++) m_pc[i] <= 0;
      end else begin
         if (bus_a.in_valid) begin
            m_q <= in_vote; m_qv <= 1'b1; m_bad <= in_bad; m_mis <= (in_bad != 3'b000);
         end else begin
            m_qv <= 1'b0; m_mis <= 1'b0; m_bad <= 3'b000;
         end
         if (bus_a.clr) begin
            m_sticky <= 1'b0; m_fail <= 3'b000; m_cnt_a <= 0; m_cnt_b <= 0;
            for (int i = 0; i < 3; i++) m_pc[i] <= 0;
         end else if (bus_a.in_valid) begin
            if (in_bad != 3'b000) begin
               m_sticky <= 1'b1;
               m_cnt_a  <= (m_cnt_a >= 255) ? 255 : m_cnt_a + 1;
               m_cnt_b  <= (m_cnt_b >= 3) ? 3 : m_cnt_b + 1;
            end
            for (int i = 0; i < 3; i++) begin
               if (in_bad[i]) begin
                  m_pc[i] <= (m_pc[i] >= 4) ? 4 : m_pc[i] + 1;
                  if (m_pc[i] + 1 >= 4) m_fail[i] <= 1'b1;
               end else begin
                  m_pc[i] <= 0;
               end
            end
         end
      end
   end

   task automatic check(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   always @(negedge c) begin
      check("a.q", int'(bus_a.q), int'(m_q));
      check("a.q_valid", int'(bus_a.q_valid), int'(m_qv));
      check("a.mismatch", int'(bus_a.mismatch), int'(m_mis));
      check("a.bad_replica", int'(bus_a.bad_replica), int'(m_bad));
      check("a.err_cnt", int'(bus_a.err_cnt), m_cnt_a);
      check("a.err_sticky", int'(bus_a.err_sticky), int'(m_sticky));
      check("a.replica_fail", int'(bus_a.replica_fail), int'(m_fail));
      check("b.q", int'(bus_b.q), int'(m_q));
      check("b.mismatch", int'(bus_b.mismatch), int'(m_mis));
      check("b.bad_replica", int'(bus_b.bad_replica), int'(m_bad));
      check("b.err_cnt", int'(bus_b.err_cnt), m_cnt_b);
      check("b.err_sticky", int'(bus_b.err_sticky), int'(m_sticky));
      check("b.replica_fail", int'(bus_b.replica_fail), int'(m_fail));
   end

   task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] d, input logic cl);
      @(negedge c);
      bus_a.in_valid = v; bus_a.d_a = a; bus_a.d_b = b; bus_a.d_c = d; bus_a.clr = cl;
      bus_b.in_valid = v; bus_b.d_a = a; bus_b.d_b = b; bus_b.d_c = d; bus_b.clr = cl;
      $display("[TB] drive v=%0b a=%02h b=%02h c=%02h clr=%0b", v, a, b, d, cl);
   endtask

   task automatic settle;
      @(posedge c);
      #1;
   endtask

   initial begin
      bus_a.in_valid = 1'b0; bus_a.d_a = '0; bus_a.d_b = '0; bus_a.d_c = '0; bus_a.clr = 1'b0;
      bus_b.in_valid = 1'b0; bus_b.d_a = '0; bus_b.d_b = '0; bus_b.d_c = '0; bus_b.clr = 1'b0;

      // Reset held with random activity
      for (int i = 0; i < 4; i++)
         drive(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
      settle();
      check("rst.q", int'(bus_a.q), 0);
      check("rst.err_cnt", int'(bus_a.err_cnt), 0);
      drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
      rst_b = 1'b1;
      drive(1'b0, 8'h11, 8'h22, 8'h33, 1'b0);
      settle();
      check("idle.q_valid", int'(bus_a.q_valid), 0);
      check("idle.q", int'(bus_a.q), 0);

      // Clean vote
      drive(1'b1, 8'hA5, 8'hA5, 8'hA5, 1'b0);
      settle();
      check("clean.q", int'(bus_a.q), 8'hA5);
      check("clean.q_valid", int'(bus_a.q_valid), 1);
      check("clean.mismatch", int'(bus_a.mismatch), 0);
      check("clean.bad", int'(bus_a.bad_replica), 0);

      // Single upset in B, then one-cycle pulse check
      drive(1'b1, 8'hA5, 8'hA4, 8'hA5, 1'b0);
      settle();
      check("single.q", int'(bus_a.q), 8'hA5);
      check("single.mismatch", int'(bus_a.mismatch), 1);
      check("single.bad", int'(bus_a.bad_replica), 3'b010);
      check("single.err_cnt", int'(bus_a.err_cnt), 1);
      check("single.sticky", int'(bus_a.err_sticky), 1);
      drive(1'b0, 8'h00, 8'hFF, 8'h0F, 1'b0);
      settle();
      check("pulse.mismatch", int'(bus_a.mismatch), 0);
      check("pulse.q_hold", int'(bus_a.q), 8'hA5);

      // Split upset: A and B wrong in different bits
      drive(1'b1, 8'h01, 8'h02, 8'h00, 1'b0);
      settle();
      check("split.q", int'(bus_a.q), 8'h00);
      check("split.bad", int'(bus_a.bad_replica), 3'b011);
      check("split.err_cnt", int'(bus_a.err_cnt), 2);

      // Persistence on C: 3 bad, 1 good, 4 bad with gaps
      drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 8'h33, 8'h33, 8'h32, 1'b0);
         drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
      end
      settle();
      check("pers3.fail", int'(bus_a.replica_fail), 0);
      drive(1'b1, 8'h33, 8'h33, 8'h33, 1'b0);
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 8'h33, 8'h33, 8'h32, 1'b0);
         drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
      end
      settle();
      check("pers7.fail", int'(bus_a.replica_fail), 0);
      drive(1'b1, 8'h33, 8'h33, 8'h32, 1'b0);
      settle();
      check("pers8.fail", int'(bus_a.replica_fail), 3'b100);
      check("pers8.err_cnt", int'(bus_a.err_cnt), 7);
      check("pers8.err_cnt_b", int'(bus_b.err_cnt), 3);
      drive(1'b1, 8'h33, 8'h33, 8'h33, 1'b0);
      settle();
      check("pers.sticky_fail", int'(bus_a.replica_fail), 3'b100);

      // Saturation on the 2-bit counter, then clr against a mismatch
      drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
      for (int i = 0; i < 5; i++) drive(1'b1, 8'hA5, 8'hA4, 8'hA5, 1'b0);
      settle();
      check("sat.err_cnt_b", int'(bus_b.err_cnt), 3);
      check("sat.err_cnt_a", int'(bus_a.err_cnt), 5);
      check("sat.fail", int'(bus_a.replica_fail), 3'b010);
      drive(1'b1, 8'hA5, 8'hA4, 8'hA5, 1'b1);
      settle();
      check("clr.err_cnt_b", int'(bus_b.err_cnt), 0);
      check("clr.sticky", int'(bus_b.err_sticky), 0);
      check("clr.fail", int'(bus_a.replica_fail), 0);
      check("clr.mismatch", int'(bus_b.mismatch), 1);
      check("clr.bad", int'(bus_b.bad_replica), 3'b010);

      // Async reset mid-stream
      drive(1'b1, 8'h5A, 8'h5A, 8'h5B, 1'b0);
      drive(1'b1, 8'h5A, 8'h5A, 8'h5B, 1'b0);
      settle();
      check("pre_rst.err_cnt", int'(bus_a.err_cnt), 2);
      check("pre_rst.q", int'(bus_a.q), 8'h5A);
      #2;
      rst_b = 1'b0;
      #1;
      check("arst.q", int'(bus_a.q), 0);
      check("arst.q_valid", int'(bus_a.q_valid), 0);
      check("arst.mismatch", int'(bus_a.mismatch), 0);
      check("arst.err_cnt", int'(bus_a.err_cnt), 0);
      check("arst.sticky", int'(bus_a.err_sticky), 0);
      drive(1'b1, 8'h5A, 8'h5A, 8'h5B, 1'b0);
      drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
      rst_b = 1'b1;
      drive(1'b1, 8'hC3, 8'hC3, 8'hC2, 1'b0);
      settle();
      check("post_rst.q", int'(bus_a.q), 8'hC3);
      check("post_rst.err_cnt", int'(bus_a.err_cnt), 1);
      check("post_rst.bad", int'(bus_a.bad_replica), 3'b100);
      drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
      drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
      settle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
